// File: rtl/alu_pipe.sv
// Registered ALU with an iterative shift-add multiplier, one op in flight at a time.
// Latency: non-MUL result valid on the edge after accept; MUL valid WIDTH/MUL_STEP+1 edges after accept.
// Backpressure: in_ready falls while a result is held unconsumed or the multiplier runs; held outputs stay stable.
//
// Ports:
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready           input handshake for src1, src2, ALU_control
//   src1, src2                  operands; src2 also supplies the shift amount
//   ALU_control                 {A_invert, B_invert/cin, op[1:0]} encoding plus SLTU/shift/MUL codes
//   out_valid/out_ready         output handshake for result, zero, cout, overflow
//   result, zero, cout, overflow registered result and flags
//   busy                        multiplier iterating
module alu_pipe #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [3:0]       ALU_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow,
    output logic             busy
);

    localparam int SHW   = $clog2(WIDTH);
    localparam int ITERS = WIDTH / MUL_STEP;
    localparam int CW    = $clog2(ITERS + 1);
    localparam int MSB   = WIDTH - 1;

    typedef enum logic {IDLE, MUL_RUN} state_t;

    state_t               state;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   step_sum;
    logic [CW-1:0]        cnt;

    logic [WIDTH:0]       add_full;
    logic [WIDTH:0]       sub_full;
    logic                 add_ovf;
    logic                 sub_ovf;
    logic [SHW-1:0]       shamt;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c;
    logic                 alu_o;

    // Dedicated subtractor so SLT/SLTU work regardless of the B_invert bit.
    assign add_full = {1'b0, src1} + {1'b0, src2};
    assign sub_full = {1'b0, src1} + {1'b0, ~src2} + {{WIDTH{1'b0}}, 1'b1};
    assign add_ovf  = (src1[MSB] == src2[MSB]) & (add_full[MSB] != src1[MSB]);
    assign sub_ovf  = (src1[MSB] != src2[MSB]) & (sub_full[MSB] != src1[MSB]);
    assign shamt    = src2[SHW-1:0];

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_o   = 1'b0;
        case (ALU_control)
            4'b0000: alu_res = src1 & src2;
            4'b0001: alu_res = src1 | src2;
            4'b0010: begin
                alu_res = add_full[WIDTH-1:0];
                alu_c   = add_full[WIDTH];
                alu_o   = add_ovf;
            end
            4'b0110: begin
                alu_res = sub_full[WIDTH-1:0];
                alu_c   = sub_full[WIDTH];
                alu_o   = sub_ovf;
            end
            // Sign of the true difference: sum sign flipped when the subtraction overflowed.
            4'b0111: alu_res = {{(WIDTH-1){1'b0}}, sub_full[MSB] ^ sub_ovf};
            4'b0011: alu_res = {{(WIDTH-1){1'b0}}, ~sub_full[WIDTH]};
            4'b1100: alu_res = ~(src1 | src2);
            4'b1000: alu_res = src1 << shamt;
            4'b1001: alu_res = src1 >> shamt;
            4'b1010: alu_res = $signed(src1) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    // One multiplier slice: add MUL_STEP shifted copies of the multiplicand.
    always_comb begin
        step_sum = acc;
        for (int j = 0; j < MUL_STEP; j++) begin
            if (mplier[j]) begin
                step_sum = step_sum + (mcand << j);
            end
        end
    end

    assign in_ready = (state == IDLE) & (~out_valid | out_ready);
    assign busy     = (state == MUL_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else if (state == IDLE) begin
            if (in_valid && in_ready) begin
                if (ALU_control == 4'b1011) begin
                    state     <= MUL_RUN;
                    mcand     <= {{WIDTH{1'b0}}, src1};
                    mplier    <= src2;
                    acc       <= '0;
                    cnt       <= '0;
                    out_valid <= 1'b0;
                end else begin
                    out_valid <= 1'b1;
                    result    <= alu_res;
                    zero      <= ~|alu_res;
                    cout      <= alu_c;
                    overflow  <= alu_o;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end else begin
            // Final edge after all iterations only publishes the product.
            if (cnt == CW'(ITERS)) begin
                state     <= IDLE;
                out_valid <= 1'b1;
                result    <= acc[WIDTH-1:0];
                zero      <= ~|acc[WIDTH-1:0];
                cout      <= 1'b0;
                overflow  <= |acc[2*WIDTH-1:WIDTH];
            end else begin
                acc    <= step_sum;
                mcand  <= mcand << MUL_STEP;
                mplier <= mplier >> MUL_STEP;
                cnt    <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: a 32-bit/step-1 instance under directed vectors and an
// 8-bit/step-2 instance under random ops with random output backpressure.
// Expected values come from an integer-arithmetic model and hand-computed literals.
module tb_alu_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic        iv32, rdy32, vld32, ordy32, z32, c32, o32, busy32;
    logic [31:0] a32, b32, res32;
    logic [3:0]  ctl32;

    logic        iv8, rdy8, vld8, z8, c8, o8, busy8;
    logic        ordy8 = 1'b1;
    logic [7:0]  a8, b8, res8;
    logic [3:0]  ctl8;

    alu_pipe #(.WIDTH(32), .MUL_STEP(1)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(rdy32),
        .src1(a32), .src2(b32), .ALU_control(ctl32),
        .out_valid(vld32), .out_ready(ordy32), .result(res32),
        .zero(z32), .cout(c32), .overflow(o32), .busy(busy32)
    );

    alu_pipe #(.WIDTH(8), .MUL_STEP(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(rdy8),
        .src1(a8), .src2(b8), .ALU_control(ctl8),
        .out_valid(vld8), .out_ready(ordy8), .result(res8),
        .zero(z8), .cout(c8), .overflow(o8), .busy(busy8)
    );

    typedef struct packed {
        logic [31:0] r;
        logic        z;
        logic        c;
        logic        o;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    int   nvec = 0;
    int   nbad = 0;
    logic rnd_on = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit values.
    function automatic exp_t model(input int w, input logic [3:0] ctl,
                                   input logic [31:0] a, input logic [31:0] b);
        longint unsigned mask, ua, ub, r, p;
        longint          sa, sb, sr, lo, hi;
        int              sh;
        logic            c, o;
        exp_t            e;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'b0, a} & mask;
        ub   = {32'b0, b} & mask;
        hi   = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo   = -(64'sd1 <<< (w - 1));
        sa   = $signed(ua);
        sb   = $signed(ub);
        if (sa > hi) sa = sa - (64'sd1 <<< w);
        if (sb > hi) sb = sb - (64'sd1 <<< w);
        sh   = int'(ub % 64'(w));
        r = 0; c = 1'b0; o = 1'b0; p = 0; sr = 0;
        case (ctl)
            4'b0000: r = ua & ub;
            4'b0001: r = ua | ub;
            4'b0010: begin
                r = (ua + ub) & mask;
                c = (ua + ub) > mask;
                sr = sa + sb;
                o = (sr < lo) || (sr > hi);
            end
            4'b0110: begin
                r = (ua - ub) & mask;
                c = ua >= ub;
                sr = sa - sb;
                o = (sr < lo) || (sr > hi);
            end
            4'b0111: r = (sa < sb) ? 64'd1 : 64'd0;
            4'b0011: r = (ua < ub) ? 64'd1 : 64'd0;
            4'b1100: r = ~(ua | ub) & mask;
            4'b1000: r = (ua << sh) & mask;
            4'b1001: r = ua >> sh;
            4'b1010: r = $unsigned(sa >>> sh) & mask;
            4'b1011: begin
                p = ua * ub;
                r = p & mask;
                o = (p >> w) != 0;
            end
            default: r = 0;
        endcase
        e.r = r[31:0];
        e.z = (r == 0);
        e.c = c;
        e.o = o;
        return e;
    endfunction

    // Scoreboard fill on every accepted op.
    always @(posedge clk) begin
        if (rst_n && iv32 && rdy32) q32.push_back(model(32, ctl32, a32, b32));
        if (rst_n && iv8 && rdy8)   q8.push_back(model(8, ctl8, {24'b0, a8}, {24'b0, b8}));
    end

    // Single compare process: every cycle an output is presented it must match the
    // oldest outstanding op; it retires only when the consumer takes it.
    always @(negedge clk) begin
        if (rst_n) begin
            if (vld32) begin
                if (q32.size() == 0) begin
                    nvec++; nbad++;
                    $display("FAIL cmp32: out_valid with no outstanding op, result %0h", res32);
                end else begin
                    check("cmp32", {res32, z32, c32, o32}, q32[0]);
                    if (ordy32) void'(q32.pop_front());
                end
            end
            if (vld8) begin
                if (q8.size() == 0) begin
                    nvec++; nbad++;
                    $display("FAIL cmp8: out_valid with no outstanding op, result %0h", res8);
                end else begin
                    check("cmp8", {24'b0, res8, z8, c8, o8}, q8[0]);
                    if (ordy8) void'(q8.pop_front());
                end
            end
        end
    end

    // Random consumer backpressure for the 8-bit instance.
    always @(posedge clk) begin
        #2 ordy8 = rnd_on ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic send32(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
        int t;
        ctl32 = ctl; a32 = a; b32 = b; iv32 = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!rdy32 && t < 200);
        if (!rdy32) begin
            nvec++; nbad++;
            $display("FAIL send32: in_ready never rose, got 0 required 1");
        end
        @(posedge clk);
        #1 iv32 = 1'b0;
    endtask

    task automatic send8(input logic [3:0] ctl, input logic [7:0] a, input logic [7:0] b);
        int t;
        ctl8 = ctl; a8 = a; b8 = b; iv8 = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!rdy8 && t < 200);
        if (!rdy8) begin
            nvec++; nbad++;
            $display("FAIL send8: in_ready never rose, got 0 required 1");
        end
        @(posedge clk);
        #1 iv8 = 1'b0;
    endtask

    // Directed 32-bit op: pin the model to the literal, then the DUT and its latency.
    task automatic dir32(input string name, input logic [3:0] ctl, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input logic ez,
                         input logic ec, input logic eo, input int elat);
        exp_t m;
        int   t;
        m = model(32, ctl, a, b);
        check({name, "_model"}, m, {er, ez, ec, eo});
        send32(ctl, a, b);
        t = 0;
        @(negedge clk);
        while (!vld32 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check({name, "_lat"}, t, elat);
        check({name, "_dut"}, {res32, z32, c32, o32}, {er, ez, ec, eo});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [3:0] ops[16] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0011, 4'b1000,
                            4'b1001, 4'b1010, 4'b1011, 4'b1011, 4'b0100, 4'b0101, 4'b1101, 4'b1111};

    initial begin
        int   edges, bad, t;
        exp_t m;
        rst_n = 1'b0;
        iv32 = 1'b0; ordy32 = 1'b1; a32 = '0; b32 = '0; ctl32 = '0;
        iv8 = 1'b0; a8 = '0; b8 = '0; ctl8 = '0;

        repeat (3) @(negedge clk);
        check("rst_out32", {vld32, busy32, res32, z32, c32, o32}, 64'd0);
        check("rst_out8", {vld8, busy8, res8, z8, c8, o8}, 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst_ready32", rdy32, 1);
        check("rst_ready8", rdy8, 1);
        @(posedge clk); #1;

        // Model pins for the 8-bit width.
        m = model(8, 4'b1011, 32'hFF, 32'hFF);
        check("m8_mul", m, {32'h01, 1'b0, 1'b0, 1'b1});
        m = model(8, 4'b1010, 32'h80, 32'h0B);
        check("m8_sra", m, {32'hF0, 1'b0, 1'b0, 1'b0});

        dir32("add_ovf",  4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 1, 0);
        dir32("sub_zero", 4'b0110, 32'd5, 32'd5, 32'h0, 1, 1, 0, 0);
        dir32("sub_ovf",  4'b0110, 32'h80000000, 32'd1, 32'h7FFFFFFF, 0, 1, 1, 0);
        dir32("slt",      4'b0111, 32'hFFFFFFFF, 32'd1, 32'd1, 0, 0, 0, 0);
        dir32("sltu",     4'b0011, 32'hFFFFFFFF, 32'd1, 32'd0, 1, 0, 0, 0);
        dir32("sra35",    4'b1010, 32'h80000000, 32'd35, 32'hF0000000, 0, 0, 0, 0);
        dir32("and",      4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0, 0);
        dir32("or",       4'b0001, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 0, 0, 0, 0);
        dir32("nor",      4'b1100, 32'h0, 32'h0, 32'hFFFFFFFF, 0, 0, 0, 0);
        dir32("sll31",    4'b1000, 32'd1, 32'd31, 32'h80000000, 0, 0, 0, 0);
        dir32("sll32",    4'b1000, 32'd1, 32'd32, 32'h00000001, 0, 0, 0, 0);
        dir32("srl",      4'b1001, 32'h80000000, 32'd4, 32'h08000000, 0, 0, 0, 0);
        dir32("add_wrap", 4'b0010, 32'hFFFFFFFF, 32'd1, 32'h0, 1, 1, 0, 0);
        dir32("undef",    4'b0100, 32'd5, 32'd5, 32'h0, 1, 0, 0, 0);
        dir32("mul_ffff", 4'b1011, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, 0, 0, 0, 33);

        // MUL: exact latency, busy high and in_ready low throughout.
        m = model(32, 4'b1011, 32'h00010000, 32'h00010000);
        check("mul_big_model", m, {32'h0, 1'b1, 1'b0, 1'b1});
        send32(4'b1011, 32'h00010000, 32'h00010000);
        a32 = 32'hDEADBEEF; b32 = 32'h12345678;
        edges = 0; bad = 0;
        while (edges < 100) begin
            @(negedge clk);
            if (vld32) break;
            if (!busy32 || rdy32) bad++;
            @(posedge clk);
            edges++;
        end
        check("mul_big_lat", edges, 33);
        check("mul_big_busy_rdy", bad, 0);
        check("mul_big_busy_end", busy32, 0);
        check("mul_big_dut", {res32, z32, c32, o32}, {32'h0, 1'b1, 1'b0, 1'b1});
        @(posedge clk); #1;

        // Backpressure: result held, in_ready low, then handshake and new accept together.
        ordy32 = 1'b0;
        send32(4'b0010, 32'd3, 32'd4);
        for (int i = 0; i < 3; i++) begin
            check("bp_hold", {vld32, rdy32, res32, z32, c32, o32}, {1'b1, 1'b0, 32'd7, 1'b0, 1'b0, 1'b0});
            @(posedge clk); #1;
        end
        ordy32 = 1'b1;
        send32(4'b0110, 32'd20, 32'd3);
        check("bp_next", {vld32, res32, z32, c32, o32}, {1'b1, 32'h11, 1'b0, 1'b1, 1'b0});
        @(posedge clk); #1;
        check("bp_drop", vld32, 0);

        // Reset in the middle of a multiply.
        send32(4'b1011, 32'd3, 32'd5);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_mul", {vld32, busy32, res32}, 64'd0);
        q32.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_mid_ready", rdy32, 1);
        @(posedge clk); #1;
        dir32("post_rst", 4'b0010, 32'd100, 32'd23, 32'd123, 0, 0, 0, 0);

        // 8-bit, 2 bits per step: 4 iterations plus the publish edge.
        send8(4'b1011, 8'h0D, 8'h0B);
        t = 0;
        @(negedge clk);
        while (!vld8 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("mul8_lat", t, 5);
        check("mul8_dut", {res8, z8, c8, o8}, {8'h8F, 1'b0, 1'b0, 1'b0});
        @(posedge clk); #1;

        rnd_on = 1'b1;
        for (int i = 0; i < 120; i++) begin
            send8(ops[$urandom_range(0, 15)], 8'($urandom), 8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        rnd_on = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("drain32", q32.size(), 0);
        check("drain8", q8.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
